// File: rtl/w_bcd_display_if.sv
// Bus between the W-register consumer side and the BCD display block:
// capture strobe and value in, conversion status, digits and segment drive out.
interface w_bcd_display_if #(
  parameter int W_WIDTH = 5
);
  logic [W_WIDTH-1:0] w_in;
  logic               w_valid;
  logic               busy;
  logic               done;
  logic [3:0]         bcd_tens;
  logic [3:0]         bcd_ones;
  logic [6:0]         seg;
  logic [1:0]         digit_en;

  modport master (
    output w_in, w_valid,
    input  busy, done, bcd_tens, bcd_ones, seg, digit_en
  );

  modport slave (
    input  w_in, w_valid,
    output busy, done, bcd_tens, bcd_ones, seg, digit_en
  );
endinterface

// File: rtl/w_bcd_display.sv
// Captures the W register value, converts it to two BCD digits with a
// shift-add-3 FSM, and scans the result onto a 2-digit 7-segment display.
module w_bcd_display #(
  parameter int W_WIDTH  = 5,
  parameter int SCAN_DIV = 4
) (
  input logic            clk,
  input logic            reset,
  w_bcd_display_if.slave bus
);
  localparam int CNT_W  = $clog2(W_WIDTH + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [W_WIDTH-1:0] bin_sr;
  logic [3:0]         scr_tens;
  logic [3:0]         scr_ones;
  logic [CNT_W-1:0]   shift_cnt;
  logic               busy_q;
  logic               done_q;
  logic [3:0]         tens_q;
  logic [3:0]         ones_q;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_en_q;
  logic [6:0]         seg_c;

  // One double-dabble step: correct nibbles >= 5, then shift the binary MSB in.
  logic [3:0] adj_tens, adj_ones, nxt_tens, nxt_ones;
  assign adj_tens = (scr_tens >= 4'd5) ? scr_tens + 4'd3 : scr_tens;
  assign adj_ones = (scr_ones >= 4'd5) ? scr_ones + 4'd3 : scr_ones;
  assign nxt_ones = {adj_ones[2:0], bin_sr[W_WIDTH-1]};
  assign nxt_tens = {adj_tens[2:0], adj_ones[3]};

  // The counter stage updates on the falling edge, so this block does too.
  // NOTE: state registers use <= so every register sees pre-edge values of the others.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin_sr    <= '0;
      scr_tens  <= '0;
      scr_ones  <= '0;
      shift_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.w_valid) begin
            bin_sr    <= bus.w_in;
            scr_tens  <= '0;
            scr_ones  <= '0;
            shift_cnt <= CNT_W'(W_WIDTH);
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scr_tens  <= nxt_tens;
          scr_ones  <= nxt_ones;
          bin_sr    <= bin_sr << 1;
          shift_cnt <= shift_cnt - CNT_W'(1);
          if (shift_cnt == CNT_W'(1)) begin
            tens_q <= nxt_tens;
            ones_q <= nxt_ones;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running scan; the digit select flips each time the counter wraps.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt   <= '0;
      digit_en_q <= 2'b01;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt   <= '0;
      digit_en_q <= ~digit_en_q;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Tens digit is blanked when zero; the ones digit always shows.
  always_comb begin
    // NOTE: default first so no path leaves seg_c unassigned and infers a latch.
    seg_c = 7'h00;
    if (digit_en_q[1]) begin
      if (tens_q != 4'd0) seg_c = seg_of(tens_q);
    end else begin
      seg_c = seg_of(ones_q);
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
  assign bus.seg      = seg_c;
  assign bus.digit_en = digit_en_q;
endmodule

// File: tb/tb_w_bcd_display.sv
// Self-checking bench for w_bcd_display: directed scenarios plus random strobes,
// checked each cycle against a transaction-level timing and arithmetic model.
module tb_w_bcd_display;
  localparam int W  = 5;
  localparam int SD = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  w_bcd_display_if #(.W_WIDTH(W)) bus ();
  w_bcd_display #(.W_WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: edge index, scan edges since reset, capture edge and value.
  int edge_k      = 0;
  int scan_n      = 0;
  int cap_edge    = -1000;
  int next_free   = 0;
  int pend_val    = 0;
  int exp_tens    = 0;
  int exp_ones    = 0;
  int model_dones = 0;
  int dut_dones   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic       e_busy, e_done;
    logic [1:0] e_de;
    logic [6:0] e_seg;
    e_busy = (edge_k >= cap_edge) && (edge_k < cap_edge + W);
    e_done = (edge_k == cap_edge + W);
    e_de   = (((scan_n / SD) % 2) == 1) ? 2'b10 : 2'b01;
    if (e_de == 2'b10) e_seg = (exp_tens == 0) ? 7'h00 : SEG_TAB[exp_tens];
    else               e_seg = SEG_TAB[exp_ones];
    check("busy",     32'(bus.busy),     32'(e_busy));
    check("done",     32'(bus.done),     32'(e_done));
    check("tens",     32'(bus.bcd_tens), 32'(exp_tens));
    check("ones",     32'(bus.bcd_ones), 32'(exp_ones));
    check("digit_en", 32'(bus.digit_en), 32'(e_de));
    check("seg",      32'(bus.seg),      32'(e_seg));
    if (bus.done) dut_dones++;
  endtask

  // One falling edge with the given inputs, then check at the following rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] w);
    bus.w_valid = v;
    bus.w_in    = w;
    @(negedge clk);
    edge_k++;
    scan_n++;
    if (edge_k == cap_edge + W) begin
      exp_tens = pend_val / 10;
      exp_ones = pend_val % 10;
      model_dones++;
    end
    if (v && edge_k >= next_free) begin
      cap_edge  = edge_k;
      pend_val  = int'(w);
      next_free = edge_k + W + 2;
    end
    @(posedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    bus.w_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_tens",     32'(bus.bcd_tens), 32'd0);
    check("rst_ones",     32'(bus.bcd_ones), 32'd0);
    check("rst_digit_en", 32'(bus.digit_en), 32'b01);
    check("rst_seg",      32'(bus.seg),      32'h3F);
    @(negedge clk);
    @(posedge clk);
    reset     = 1'b0;
    scan_n    = 0;
    cap_edge  = -1000;
    next_free = 0;
    exp_tens  = 0;
    exp_ones  = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom_range(31, 0)));
  endtask

  initial begin
    bus.w_valid = 1'b0;
    bus.w_in    = '0;

    // Reset state, then tens position blanked after the first scan wrap.
    do_reset();
    idle(SD);
    check("blank_de",  32'(bus.digit_en), 32'b10);
    check("blank_seg", 32'(bus.seg),      32'h00);

    // Single conversion of 13 with scan over both digits.
    cycle(1'b1, W'(13));
    idle(2 * SD + 2);
    check("c13_tens", 32'(bus.bcd_tens), 32'd1);
    check("c13_ones", 32'(bus.bcd_ones), 32'd3);

    // 31 then 9 (tens blanked for 9).
    cycle(1'b1, W'(31));
    idle(W + 2);
    check("c31_tens", 32'(bus.bcd_tens), 32'd3);
    check("c31_ones", 32'(bus.bcd_ones), 32'd1);
    cycle(1'b1, W'(9));
    idle(2 * SD + 2);
    check("c9_tens", 32'(bus.bcd_tens), 32'd0);
    check("c9_ones", 32'(bus.bcd_ones), 32'd9);

    // Strobe during SHIFT is dropped.
    model_dones = 0;
    dut_dones   = 0;
    cycle(1'b1, W'(7));
    cycle(1'b0, W'(0));
    cycle(1'b1, W'(20));
    idle(W + 4);
    check("ign_tens",  32'(bus.bcd_tens), 32'd0);
    check("ign_ones",  32'(bus.bcd_ones), 32'd7);
    check("ign_dones", 32'(dut_dones),    32'd1);

    // Reset during the third SHIFT cycle aborts, then a clean conversion.
    cycle(1'b1, W'(18));
    cycle(1'b0, W'(0));
    cycle(1'b0, W'(0));
    do_reset();
    idle(W + 2);
    cycle(1'b1, W'(25));
    idle(W + 2);
    check("c25_tens", 32'(bus.bcd_tens), 32'd2);
    check("c25_ones", 32'(bus.bcd_ones), 32'd5);

    // w_valid held high: a done every W+2 cycles.
    model_dones = 0;
    dut_dones   = 0;
    for (int i = 0; i < 5 * (W + 2); i++) cycle(1'b1, W'(17));
    check("hold_dones", 32'(dut_dones), 32'(model_dones));
    check("hold_tens",  32'(bus.bcd_tens), 32'd1);
    check("hold_ones",  32'(bus.bcd_ones), 32'd7);

    // Random strobes and values, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) == 0) do_reset();
      cycle($urandom_range(3, 0) == 0, W'($urandom_range(31, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
